// File: rtl/ex_rs_pkg.sv
// rtl/ex_rs_pkg.sv - shared constants and entry layout for execution-side reservation stations
//
// Purpose: execution-unit codes, the "no dependency" tag value, op codes and
// the default reservation-station entry layout shared by every station.
// Ports: none (package).

package ex_rs_pkg;

  // Execution-unit codes carried on the dispatch ex_unit field.
  localparam int UNIT_ALU = 0;
  localparam int UNIT_MUL = 1;
  localparam int UNIT_LSU = 2;
  localparam int UNIT_BRU = 3;

  // Tag value meaning "operand value present, nothing to wait for".
  localparam int TAG_NONE = 0;

  // A few op codes used by the ALU station.
  localparam logic [5:0] OP_ADD = 6'd1;
  localparam logic [5:0] OP_SUB = 6'd2;
  localparam logic [5:0] OP_AND = 6'd3;
  localparam logic [5:0] OP_XOR = 6'd4;

  // Default-width entry layout for stations built with the standard widths.
  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [31:0] val1;
    logic [3:0]  tag1;
    logic [31:0] val2;
    logic [3:0]  tag2;
    logic [3:0]  target;
    logic [31:0] pc_addr;
    logic [31:0] offset;
  } rs_entry_t;

endpackage

// File: rtl/rs_select.sv
// rtl/rs_select.sv - lowest-index priority picker over a request vector
//
// Purpose: combinational priority select, lowest set bit wins.
// Ports:
//   req   in   N      request vector
//   grant out  N      one-hot grant (all zero when no request)
//   idx   out  IDX_W  index of the granted bit (0 when no request)

module rs_select #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest requesting index is the last write.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ex_rs.sv
// rtl/ex_rs.sv - reservation station on the receiving end of ID->EX dispatch
//
// Purpose: detects toggle-coded dispatch events for this unit, holds them in
// a small station, resolves operand tags from the CDB, and issues ready
// entries to the functional unit over a valid/ready handshake.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_ce                         dispatch toggle, each level change = one instruction
//   in_unit/in_op/in_val1/in_val2/in_tag1/in_tag2/in_target/in_pc_addr/in_offset
//                                 dispatched instruction fields
//   cdb_valid/cdb_tag/cdb_val     common data bus broadcast
//   flush                         squash all entries
//   rs_full                       every entry occupied
//   iss_valid/iss_ready           issue handshake
//   iss_op/iss_a/iss_b/iss_target/iss_pc/iss_offset  selected entry contents
//   err_overflow                  sticky: dispatch arrived while full

module ex_rs
  import ex_rs_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 6,
  parameter int ADDR_W  = 32,
  parameter int UNIT_W  = 3,
  parameter int MY_UNIT = UNIT_ALU
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_ce,
  input  logic [UNIT_W-1:0] in_unit,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_val1,
  input  logic [DATA_W-1:0] in_val2,
  input  logic [TAG_W-1:0]  in_tag1,
  input  logic [TAG_W-1:0]  in_tag2,
  input  logic [TAG_W-1:0]  in_target,
  input  logic [ADDR_W-1:0] in_pc_addr,
  input  logic [ADDR_W-1:0] in_offset,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_val,
  input  logic              flush,
  output logic              rs_full,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [OP_W-1:0]   iss_op,
  output logic [DATA_W-1:0] iss_a,
  output logic [DATA_W-1:0] iss_b,
  output logic [TAG_W-1:0]  iss_target,
  output logic [ADDR_W-1:0] iss_pc,
  output logic [ADDR_W-1:0] iss_offset,
  output logic              err_overflow
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(TAG_NONE);

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] val1;
    logic [TAG_W-1:0]  tag1;
    logic [DATA_W-1:0] val2;
    logic [TAG_W-1:0]  tag2;
    logic [TAG_W-1:0]  target;
    logic [ADDR_W-1:0] pc_addr;
    logic [ADDR_W-1:0] offset;
  } entry_t;

  entry_t           ent [DEPTH];
  entry_t           new_ent;
  logic             last_ce;
  logic             err_q;
  logic             lock_q;
  logic [IDX_W-1:0] lock_idx;

  logic [DEPTH-1:0] valid_vec, ready_vec;
  logic [DEPTH-1:0] rdy_grant, free_grant;
  logic [IDX_W-1:0] rdy_idx, free_idx, sel_idx;
  logic             accept, fire;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ent[i].valid;
      ready_vec[i] = ent[i].valid && (ent[i].tag1 == NO_TAG) && (ent[i].tag2 == NO_TAG);
    end
  end

  rs_select #(.N(DEPTH), .IDX_W(IDX_W)) u_pick_issue (
    .req   (ready_vec),
    .grant (rdy_grant),
    .idx   (rdy_idx)
  );

  // Allocation looks only at registered occupancy, so a slot freed by an
  // issue this cycle cannot be handed out until the next one.
  rs_select #(.N(DEPTH), .IDX_W(IDX_W)) u_pick_free (
    .req   (~valid_vec),
    .grant (free_grant),
    .idx   (free_idx)
  );

  // A stalled issue keeps its entry: the lock pins the selection so a
  // lower-index entry waking up cannot swap the presented instruction.
  assign sel_idx   = lock_q ? lock_idx : rdy_idx;
  assign iss_valid = (lock_q || (|rdy_grant)) && !flush;
  assign fire      = iss_valid && iss_ready;
  assign rs_full   = &valid_vec;
  assign err_overflow = err_q;

  assign accept = (in_ce != last_ce) && (in_unit == UNIT_W'(MY_UNIT)) && !flush;

  always_comb begin
    iss_op     = '0;
    iss_a      = '0;
    iss_b      = '0;
    iss_target = '0;
    iss_pc     = '0;
    iss_offset = '0;
    if (iss_valid) begin
      iss_op     = ent[sel_idx].op;
      iss_a      = ent[sel_idx].val1;
      iss_b      = ent[sel_idx].val2;
      iss_target = ent[sel_idx].target;
      iss_pc     = ent[sel_idx].pc_addr;
      iss_offset = ent[sel_idx].offset;
    end
  end

  // Incoming entry, with a same-cycle CDB match resolved on the way in.
  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.op      = in_op;
    new_ent.val1    = in_val1;
    new_ent.tag1    = in_tag1;
    new_ent.val2    = in_val2;
    new_ent.tag2    = in_tag2;
    new_ent.target  = in_target;
    new_ent.pc_addr = in_pc_addr;
    new_ent.offset  = in_offset;
    if (cdb_valid && (in_tag1 != NO_TAG) && (in_tag1 == cdb_tag)) begin
      new_ent.val1 = cdb_val;
      new_ent.tag1 = NO_TAG;
    end
    if (cdb_valid && (in_tag2 != NO_TAG) && (in_tag2 == cdb_tag)) begin
      new_ent.val2 = cdb_val;
      new_ent.tag2 = NO_TAG;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      last_ce  <= 1'b0;
      err_q    <= 1'b0;
      lock_q   <= 1'b0;
      lock_idx <= '0;
    end else begin
      last_ce <= in_ce;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
        lock_q <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent[i].valid && cdb_valid) begin
            if ((ent[i].tag1 != NO_TAG) && (ent[i].tag1 == cdb_tag)) begin
              ent[i].val1 <= cdb_val;
              ent[i].tag1 <= NO_TAG;
            end
            if ((ent[i].tag2 != NO_TAG) && (ent[i].tag2 == cdb_tag)) begin
              ent[i].val2 <= cdb_val;
              ent[i].tag2 <= NO_TAG;
            end
          end
        end
        if (fire) begin
          ent[sel_idx].valid <= 1'b0;
          lock_q             <= 1'b0;
        end else if (iss_valid) begin
          lock_q   <= 1'b1;
          lock_idx <= sel_idx;
        end
        if (accept) begin
          if (~|free_grant) err_q <= 1'b1;
          else              ent[free_idx] <= new_ent;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_rs.sv
// tb/tb_ex_rs.sv - scoreboard bench for ex_rs with directed and random dispatch traffic

module tb_ex_rs;
  import ex_rs_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW = 32, TW = 4, OW = 6, AW = 32, UW = 3;
  localparam int MY = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_ce;
  logic [UW-1:0] in_unit;
  logic [OW-1:0] in_op;
  logic [DW-1:0] in_val1, in_val2;
  logic [TW-1:0] in_tag1, in_tag2, in_target;
  logic [AW-1:0] in_pc_addr, in_offset;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_val;
  logic          flush;
  logic          rs_full, iss_valid, iss_ready, err_overflow;
  logic [OW-1:0] iss_op;
  logic [DW-1:0] iss_a, iss_b;
  logic [TW-1:0] iss_target;
  logic [AW-1:0] iss_pc, iss_offset;

  ex_rs #(.DEPTH(DEPTH), .DATA_W(DW), .TAG_W(TW), .OP_W(OW), .ADDR_W(AW),
          .UNIT_W(UW), .MY_UNIT(MY)) dut (
    .clk(clk), .rst(rst), .in_ce(in_ce), .in_unit(in_unit), .in_op(in_op),
    .in_val1(in_val1), .in_val2(in_val2), .in_tag1(in_tag1), .in_tag2(in_tag2),
    .in_target(in_target), .in_pc_addr(in_pc_addr), .in_offset(in_offset),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .flush(flush),
    .rs_full(rs_full), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_op(iss_op), .iss_a(iss_a), .iss_b(iss_b), .iss_target(iss_target),
    .iss_pc(iss_pc), .iss_offset(iss_offset), .err_overflow(err_overflow)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 0;

  logic [191:0] isq[$];
  logic [2:0]   stq[$];

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the station as a set of slots with plain per-slot fields.
  bit            m_v[DEPTH];
  logic [OW-1:0] m_op[DEPTH];
  logic [DW-1:0] m_a[DEPTH], m_b[DEPTH];
  logic [TW-1:0] m_t1[DEPTH], m_t2[DEPTH], m_tgt[DEPTH];
  logic [AW-1:0] m_pc[DEPTH], m_off[DEPTH];
  int            m_offer_held;
  bit            m_last, m_err;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
    m_offer_held = -1;
    m_last = 0;
    m_err = 0;
  endtask

  // Called with this cycle's inputs applied: records what the DUT must show
  // now, then advances the model to the state after the coming edge.
  task automatic model_eval();
    int offer, freei;
    bit all_busy, ev;
    offer = -1;
    if (!flush) begin
      if (m_offer_held >= 0) offer = m_offer_held;
      else for (int i = DEPTH - 1; i >= 0; i--)
        if (m_v[i] && m_t1[i] == 0 && m_t2[i] == 0) offer = i;
    end
    all_busy = 1;
    freei = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m_v[i]) begin all_busy = 0; freei = i; end
    stq.push_back({all_busy, m_err, offer >= 0});
    if (offer >= 0 && iss_ready)
      isq.push_back({m_op[offer], m_a[offer], m_b[offer], m_tgt[offer], m_pc[offer], m_off[offer]});

    ev = (in_ce != m_last);
    m_last = in_ce;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
      m_offer_held = -1;
    end else begin
      if (offer >= 0) m_offer_held = iss_ready ? -1 : offer;
      if (offer >= 0 && iss_ready) m_v[offer] = 0;
      if (cdb_valid) for (int i = 0; i < DEPTH; i++) if (m_v[i]) begin
        if (m_t1[i] != 0 && m_t1[i] == cdb_tag) begin m_a[i] = cdb_val; m_t1[i] = 0; end
        if (m_t2[i] != 0 && m_t2[i] == cdb_tag) begin m_b[i] = cdb_val; m_t2[i] = 0; end
      end
      if (ev && in_unit == UW'(MY)) begin
        if (all_busy) m_err = 1;
        else begin
          m_v[freei] = 1;
          m_op[freei] = in_op;   m_tgt[freei] = in_target;
          m_pc[freei] = in_pc_addr; m_off[freei] = in_offset;
          m_a[freei] = in_val1;  m_t1[freei] = in_tag1;
          m_b[freei] = in_val2;  m_t2[freei] = in_tag2;
          if (cdb_valid && in_tag1 != 0 && in_tag1 == cdb_tag) begin m_a[freei] = cdb_val; m_t1[freei] = 0; end
          if (cdb_valid && in_tag2 != 0 && in_tag2 == cdb_tag) begin m_b[freei] = cdb_val; m_t2[freei] = 0; end
        end
      end
    end
  endtask

  // Monitor: pops one status record per cycle and one issue record per handshake.
  initial begin
    logic [2:0]   st;
    logic [191:0] rec, prev_rec;
    bit           prev_stall;
    prev_stall = 0;
    prev_rec = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_stall = 0;
      end else begin
        rec = {iss_op, iss_a, iss_b, iss_target, iss_pc, iss_offset};
        if (stq.size() == 0) chk("status_queue_empty", 1, 0);
        else begin
          st = stq.pop_front();
          chk("status_full_err_valid", {rs_full, err_overflow, iss_valid}, st);
        end
        if (iss_valid && iss_ready) begin
          if (isq.size() == 0) chk("unexpected_issue", rec, 0);
          else chk("issue_fields", rec, isq.pop_front());
        end
        if (!iss_valid) chk("idle_outputs_zero", rec, 0);
        if (prev_stall && !flush) chk("stall_hold", {iss_valid, rec[137:0]}, {1'b1, prev_rec[137:0]});
        prev_stall = iss_valid && !iss_ready && !flush;
        prev_rec = rec;
      end
    end
  end

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cdb_valid = 0;
    flush = 0;
    in_unit = 3'd5;
  endtask

  task automatic disp(input logic [2:0] u, input logic [5:0] op, input logic [31:0] v1,
                      input logic [3:0] t1, input logic [31:0] v2, input logic [3:0] t2,
                      input logic [3:0] tg);
    in_ce = ~in_ce;
    in_unit = u;
    in_op = op;
    in_val1 = v1; in_tag1 = t1;
    in_val2 = v2; in_tag2 = t2;
    in_target = tg;
    in_pc_addr = 32'h1000 + 32'(tg) * 4;
    in_offset = 32'(tg) + 32'h40;
  endtask

  initial begin
    rst = 1;
    in_ce = 0; in_unit = 0; in_op = 0; in_val1 = 0; in_val2 = 0;
    in_tag1 = 0; in_tag2 = 0; in_target = 0; in_pc_addr = 0; in_offset = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_val = 0; flush = 0; iss_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_status", {rs_full, err_overflow, iss_valid}, 0);
    chk("reset_iss_a", iss_a, 0);
    rst = 0;
    mon_en = 1;

    idle(); iss_ready = 1; step();
    // single ready dispatch, plus one for another unit that must be ignored
    disp(0, OP_ADD, 5, 0, 7, 0, 1); step();
    disp(2, OP_ADD, 8, 0, 9, 0, 15); step();
    idle(); repeat (3) step();
    // wakeup via CDB two cycles after dispatch
    disp(0, OP_SUB, 1, 3, 2, 0, 2); step();
    idle(); step();
    cdb_valid = 1; cdb_tag = 3; cdb_val = 32'hDEAD; step();
    idle(); repeat (3) step();
    // allocation bypass
    disp(0, OP_ADD, 11, 0, 0, 2, 3); cdb_valid = 1; cdb_tag = 2; cdb_val = 9; step();
    idle(); repeat (2) step();
    // overflow: five dispatches into four slots while stalled
    iss_ready = 0;
    for (int i = 0; i < 5; i++) begin
      disp(0, OP_ADD, 32'(i), 0, 32'(i + 100), 0, 4'(4 + i)); step();
    end
    idle(); repeat (2) step();
    chk("overflow_sticky", err_overflow, 1);
    iss_ready = 1; repeat (6) step();
    // stalled issue is not preempted by a lower entry waking up
    iss_ready = 0;
    disp(0, OP_XOR, 0, 5, 1, 0, 9); step();
    disp(0, OP_AND, 2, 0, 3, 0, 10); step();
    idle(); step();
    cdb_valid = 1; cdb_tag = 5; cdb_val = 32'h55; step();
    idle(); repeat (3) step();
    iss_ready = 1; repeat (3) step();
    // flush with simultaneous toggle, then normal dispatch
    iss_ready = 0;
    for (int i = 0; i < 3; i++) begin
      disp(0, OP_ADD, 32'(i), 6, 1, 0, 4'(11 + i)); step();
    end
    idle(); flush = 1; in_ce = ~in_ce; in_unit = 0; step();
    idle(); iss_ready = 1; step();
    disp(0, OP_ADD, 1, 0, 2, 0, 14); step();
    idle(); repeat (3) step();

    // asynchronous reset mid-operation with in_ce high: counts as a new event
    mon_en = 0;
    disp(0, OP_SUB, 3, 0, 4, 0, 7);
    in_ce = 1;
    #1 rst = 1;
    #1;
    chk("midreset_status", {rs_full, err_overflow, iss_valid}, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    mon_en = 1;
    step();
    idle(); repeat (2) step();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0) in_ce = ~in_ce;
      in_unit = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'(MY);
      in_op = 6'($urandom);
      in_val1 = $urandom; in_val2 = $urandom;
      in_tag1 = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 5));
      in_tag2 = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 5));
      in_target = 4'($urandom);
      in_pc_addr = $urandom; in_offset = $urandom;
      cdb_valid = 1'($urandom_range(0, 1));
      cdb_tag = 4'($urandom_range(1, 5));
      cdb_val = $urandom;
      flush = ($urandom_range(0, 40) == 0);
      iss_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    mon_en = 0;
    chk("issue_queue_drained", 192'(isq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_rs.md
Name: ex_rs

Overview:
- EX-side receiving end of the ID→EX dispatch interface; one instance per execution unit.
- Detects new-instruction events signalled by the toggling ce line.
- Captures instructions addressed to its unit into a small reservation station and snoops the CDB to resolve operand tags.
- Issues ready instructions to the functional unit over a valid/ready handshake, and exports a full signal so ID can stall.

Parameters:
- DEPTH, 4, number of reservation-station entries (power of two, 2..8)
- DATA_W, 32, operand/value width
- TAG_W, 4, rename tag width; tag 0 means "value present, no dependency"
- OP_W, 6, op field width
- ADDR_W, 32, pc_addr/offset width
- UNIT_W, 3, ex_unit field width
- MY_UNIT, 0, ex_unit code this instance accepts

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_ce  in  1  dispatch toggle; every change of level marks one new instruction
- in_unit  in  UNIT_W  destination execution unit
- in_op  in  OP_W  operation
- in_val1/in_val2  in  DATA_W  operand values (meaningful when tag is 0)
- in_tag1/in_tag2  in  TAG_W  operand producer tags
- in_target  in  TAG_W  result tag
- in_pc_addr  in  ADDR_W  instruction pc
- in_offset  in  ADDR_W  immediate/offset
- cdb_valid  in  1  common data bus broadcast valid
- cdb_tag  in  TAG_W  broadcast tag (never 0 when valid)
- cdb_val  in  DATA_W  broadcast value
- flush  in  1  squash all entries
- rs_full  out  1  occupancy == DEPTH
- iss_valid  out  1  an entry is ready to issue
- iss_ready  in  1  functional unit accepts
- iss_op/iss_a/iss_b/iss_target/iss_pc/iss_offset  out  per fields  selected entry contents
- err_overflow  out  1  sticky: dispatch arrived while full

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: all entries invalid; last_ce=0; rs_full=0; iss_valid=0; err_overflow=0. All iss_* data outputs are 0 while iss_valid=0.
- Event detect: new = (in_ce != last_ce). last_ce <= in_ce every cycle, including flush cycles.
- Event filter: an event is accepted only if in_unit==MY_UNIT; other-unit events are ignored.
- Allocation: an accepted event writes the lowest-index entry that was free at the start of the cycle. The entry is visible (can be selected) the next cycle.
- Full handling: if all entries are occupied, the event is dropped and err_overflow is set. err_overflow clears only on rst.
- Allocation bypass: if cdb_valid and cdb_tag equals a nonzero incoming tag in the same cycle, the entry stores cdb_val with tag 0.
- Wakeup: each cycle, every valid entry whose tagN==cdb_tag (cdb_valid, tagN!=0) latches cdb_val into valN and sets tagN=0. An entry woken this way can issue the following cycle.
- Ready and select: an entry is ready when it is valid and tag1==tag2==0. Selection is combinational, lowest-index ready entry, via sub-module.
- Issue: iss_valid and iss_* are driven combinationally from the selected entry (iss_a=val1, iss_b=val2). On iss_valid&&iss_ready the entry is freed at the clock edge.
- Issue handshake: iss_* must stay stable while iss_valid&&!iss_ready, unless flush. A lower-index entry becoming ready must not preempt a stalled issue: the selection is locked until accepted.
- Slot reuse: a slot freed by issue is not reallocated in the same cycle. rs_full is derived from registered occupancy.
- Flush: clears all entries next edge and releases the selection lock. Any event in the flush cycle is consumed (last_ce updates) and discarded. iss_valid is forced 0 during the flush cycle.
- Mid-operation reset: asynchronous return to reset values. The toggle in flight at reset is treated as consumed only if in_ce==0.

Decomposition:
- Add to common_def.h: rs_entry_t struct (valid, op, val1, tag1, val2, tag2, target, pc_addr, offset), ex-unit code constants, TAG_NONE=0.
- Sub-module rs_select: parameterised lowest-index priority picker over a ready vector. Outputs one-hot grant plus index; also used by other stations.

Test Plan:
- Toggle in_ce 0→1, unit=MY_UNIT, tags 0, val1=5, val2=7, op=ADD, iss_ready=1 → next cycle iss_valid=1, iss_a=5, iss_b=7; entry freed; no second issue.
- Dispatch with tag1=3; two cycles later cdb_valid, tag 3, val 0xDEAD → iss_valid rises the cycle after the broadcast with iss_a=0xDEAD.
- Dispatch with tag2=2 in the same cycle as cdb tag 2, val 9 → issues next cycle with iss_b=9 (allocation bypass).
- Five dispatches, iss_ready=0, DEPTH=4 → rs_full=1 after the fourth; fifth dropped; err_overflow=1; with iss_ready=1 exactly 4 issues in entry order 0..3.
- Hold iss_ready=0 with entry1 ready, then entry0 becomes ready → iss_* stay on entry1 until accepted.
- Three entries pending, flush with a simultaneous in_ce toggle → all entries empty next cycle, rs_full=0, no issue; the next toggle is accepted normally.
